rv_imm_stage: RTL
=================

RV_IMM_STAGE -- requirements
Module: rv_imm_stage

Interface
REQ-001 Parameter XLEN, default 32, datapath width; legal values 32 and 64.
REQ-002 Parameter SKID_EN, default 1, 1 = two-entry output buffer (main + skid), 0 = single entry.
REQ-003 Port clk input 1, single clock; all state updates on rising edge.
REQ-004 Port rst_n input 1, asynchronous active-low reset.
REQ-005 Port flush input 1, synchronous pipeline flush.
REQ-006 Port in_valid input 1, upstream has an instruction.
REQ-007 Port in_ready output 1, stage can accept an instruction this cycle.
REQ-008 Port instruction input 32, raw instruction word.
REQ-009 Port pc input XLEN, PC of the instruction.
REQ-010 Port imm_type input 3, format select: 0 I, 1 S, 2 B, 3 U, 4 J, 5 Z (CSR uimm), 6 SH (shift amount), 7 reserved.
REQ-011 Port out_valid output 1, buffered result available.
REQ-012 Port out_ready input 1, downstream accepts the result.
REQ-013 Port imm_out output XLEN, extended immediate.
REQ-014 Port target_out output XLEN, pc + imm_out.
REQ-015 Port imm_err output 1, result came from reserved imm_type.

Function
REQ-016 Accept on in_valid && in_ready; transfer on out_valid && out_ready.
REQ-017 Latency is 1 cycle: a result accepted at edge N is visible on outputs after edge N when the buffer was empty.
REQ-018 I/S/B/J formats follow RV32 bit placement, sign-extended from instruction[31] to XLEN.
REQ-019 U format is {instruction[31:12], 12'b0}; for XLEN=64 bits 63:32 replicate instruction[31].
REQ-020 Z format zero-extends instruction[19:15].
REQ-021 SH format zero-extends instruction[24:20] when XLEN=32 and instruction[25:20] when XLEN=64.
REQ-022 Reserved type 7: imm_out = 0, target_out = pc, imm_err = 1; the result still flows through the handshake.
REQ-023 target_out = pc + imm_out modulo 2^XLEN; carry out is discarded, so wrap-around is silent.
REQ-024 imm_out, target_out and imm_err are registered. They come from buffer state only, with no combinational path from instruction, pc or imm_type.
REQ-025 in_ready is registered. It equals "skid entry empty" when SKID_EN=1, and "main empty or out_ready" when SKID_EN=0.
REQ-026 SKID_EN=1 buffer states are EMPTY, ONE (main valid) and FULL (main and skid valid).
REQ-027 EMPTY + accept -> ONE.
REQ-028 ONE + accept without drain -> FULL; the new entry goes to skid.
REQ-029 ONE + drain without accept -> EMPTY.
REQ-030 ONE + accept with drain -> ONE; the new entry replaces main.
REQ-031 FULL + drain -> ONE; skid moves to main. FULL never accepts.
REQ-032 Outputs hold stable while out_valid && !out_ready.
REQ-033 flush empties all entries at the next edge, drops any simultaneous in_valid, and forces out_valid = 0 and in_ready = 1 after that edge.
REQ-034 flush has priority over accept and drain in the same cycle.
REQ-035 Data values in empty entries are don't-care, but X must never propagate to out_valid or in_ready.

Reset
REQ-036 While rst_n = 0 the block asynchronously drives out_valid = 0, in_ready = 0, imm_out = 0, target_out = 0 and imm_err = 0, and empties the buffer.
REQ-037 in_ready rises on the first clk edge after rst_n deasserts.
REQ-038 Reset asserted mid-transfer discards all entries with no partial output.

Verification
REQ-039 XLEN=32; I-type instruction 0xFFF00093 (addi x1,x0,-1), pc=0x100 -> imm_out 0xFFFFFFFF, target_out 0x000000FF, one cycle later.
REQ-040 XLEN=32; J-type instruction 0x0000006F immediate 0 replaced by 0x8000006F, pc=0x00001000 -> imm_out 0xFFF00000, target_out 0xFFF01000.
REQ-041 XLEN=64; U-type instruction 0x800000B7, pc=0 -> imm_out 0xFFFFFFFF80000000; SH with instruction[25:20] = 0x3F -> imm_out 63.
REQ-042 SKID_EN=1; hold out_ready = 0 and offer 3 instructions back-to-back -> 2 accepted, in_ready = 0 afterwards; then release out_ready -> both emerge in order on consecutive cycles.
REQ-043 With the buffer FULL, assert flush together with in_valid -> out_valid = 0 and in_ready = 1 next cycle; the flushed data never appears.
REQ-044 imm_type = 7 with pc = 0xFFFFFFFC -> imm_err 1, imm_out 0, target_out 0xFFFFFFFC; B-type offset +8 at the same pc -> target_out 0x00000004 (wrap).

Source files
------------

// File: rtl/rv_imm_stage.sv
// RISC-V immediate extraction stage: decodes the immediate for the selected format,
// computes pc + imm, and holds results in a main/skid output buffer behind a valid/ready handshake.
module rv_imm_stage #(
  parameter int XLEN    = 32,
  parameter bit SKID_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instruction,
  input  logic [XLEN-1:0] pc,
  input  logic [2:0]      imm_type,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] imm_out,
  output logic [XLEN-1:0] target_out,
  output logic            imm_err
);

  typedef enum logic [2:0] {
    IMM_I   = 3'd0,
    IMM_S   = 3'd1,
    IMM_B   = 3'd2,
    IMM_U   = 3'd3,
    IMM_J   = 3'd4,
    IMM_Z   = 3'd5,
    IMM_SH  = 3'd6,
    IMM_RSV = 3'd7
  } imm_type_e;

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] target;
    logic            err;
  } entry_t;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return XLEN'($signed(v));
  endfunction

  entry_t new_entry;
  entry_t main_q, main_nxt;
  entry_t skid_q, skid_nxt;
  logic   main_valid_q, main_valid_nxt;
  logic   skid_valid_q, skid_valid_nxt;
  logic   in_ready_q, in_ready_nxt;
  logic   accept, drain;
  logic   unused_opcode;

  // The opcode field never contributes to any immediate.
  assign unused_opcode = ^instruction[6:0];

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    new_entry.imm = '0;
    unique case (imm_type_e'(imm_type))
      IMM_I:   new_entry.imm = sext32({{20{instruction[31]}}, instruction[31:20]});
      IMM_S:   new_entry.imm = sext32({{20{instruction[31]}}, instruction[31:25], instruction[11:7]});
      IMM_B:   new_entry.imm = sext32({{20{instruction[31]}}, instruction[7], instruction[30:25],
                                       instruction[11:8], 1'b0});
      IMM_U:   new_entry.imm = sext32({instruction[31:12], 12'b0});
      IMM_J:   new_entry.imm = sext32({{12{instruction[31]}}, instruction[19:12], instruction[20],
                                       instruction[30:21], 1'b0});
      IMM_Z:   new_entry.imm = XLEN'(instruction[19:15]);
      IMM_SH:  new_entry.imm = (XLEN == 64) ? XLEN'(instruction[25:20]) : XLEN'(instruction[24:20]);
      IMM_RSV: new_entry.imm = '0;
      default: new_entry.imm = '0;
    endcase
    // Carry out of the add is dropped, so targets wrap modulo 2^XLEN.
    new_entry.target = pc + new_entry.imm;
    new_entry.err    = (imm_type == IMM_RSV);
  end

  assign accept = in_valid && in_ready_q;
  assign drain  = main_valid_q && out_ready;

  always_comb begin
    main_nxt       = main_q;
    skid_nxt       = skid_q;
    main_valid_nxt = main_valid_q;
    skid_valid_nxt = skid_valid_q;
    if (flush) begin
      main_valid_nxt = 1'b0;
      skid_valid_nxt = 1'b0;
    end else if (main_valid_q && !drain) begin
      // Main is stalled; a new entry can only park in the skid slot.
      if (accept && SKID_EN) begin
        skid_nxt       = new_entry;
        skid_valid_nxt = 1'b1;
      end
    end else if (skid_valid_q) begin
      main_nxt       = skid_q;
      main_valid_nxt = 1'b1;
      skid_valid_nxt = 1'b0;
    end else if (accept) begin
      main_nxt       = new_entry;
      main_valid_nxt = 1'b1;
    end else begin
      main_valid_nxt = 1'b0;
    end
    // Ready is registered, so it may only advertise space guaranteed to exist next cycle.
    in_ready_nxt = SKID_EN ? !skid_valid_nxt : !main_valid_nxt;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  // NOTE: data entries are reset too, because imm_out/target_out/imm_err must read zero during reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b0;
    end else begin
      main_q       <= main_nxt;
      skid_q       <= skid_nxt;
      main_valid_q <= main_valid_nxt;
      skid_valid_q <= skid_valid_nxt;
      in_ready_q   <= in_ready_nxt;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = main_valid_q;
  assign imm_out    = main_q.imm;
  assign target_out = main_q.target;
  assign imm_err    = main_q.err;

endmodule
